// File: rtl/pwm_generator_pkg.sv
// Shared definitions for the PCA9685-style PWM block: counter geometry,
// register byte layout, FSM encodings and a small prescale helper.
package pwm_generator_pkg;

  localparam int PWM_CNT_W = 12;
  localparam logic [PWM_CNT_W-1:0] PWM_CNT_MAX = 12'd4095;

  // Byte positions inside one channel's 32-bit register group
  localparam int BYTE_ON_L  = 0;
  localparam int BYTE_ON_H  = 1;
  localparam int BYTE_OFF_L = 2;
  localparam int BYTE_OFF_H = 3;

  // Bit inside ON_H / OFF_H that forces the channel fully on / off
  localparam int FULL_BIT = 4;

  localparam logic [0:0] ST_SLEEP = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // One channel's register group; ON_L arrives first so it is the MSB byte
  typedef struct packed {
    logic [7:0] on_l;
    logic [7:0] on_h;
    logic [7:0] off_l;
    logic [7:0] off_h;
  } chan_regs_t;

  // Prescale values below the floor would run the counter too fast
  function automatic logic [7:0] clamp_prescale(input logic [7:0] value,
                                                input logic [7:0] floor_val);
    return (value < floor_val) ? floor_val : value;
  endfunction

endpackage

// File: rtl/pwm_generator_channel.sv
// One PWM output: decodes its ON/OFF window from the shadow slice, compares
// against the shared counter and registers the pad level and drive enable.
module pwm_channel
  import pwm_generator_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [31:0]          shadow_i,
  input  logic [PWM_CNT_W-1:0] counter_i,
  input  logic                 run_i,
  input  logic                 invrt_i,
  input  logic                 outdrv_i,
  input  logic                 oe_ni,
  output logic                 pwm_o,
  output logic                 pwm_oe_o
);

  chan_regs_t           regs;
  logic [PWM_CNT_W-1:0] on_cnt;
  logic [PWM_CNT_W-1:0] off_cnt;
  logic                 full_on;
  logic                 full_off;
  logic                 raw;
  logic                 level;
  logic                 pwm_d;
  logic                 oe_d;
  logic                 unused_reserved;

  assign regs     = shadow_i;
  assign on_cnt   = {regs.on_h[3:0], regs.on_l};
  assign off_cnt  = {regs.off_h[3:0], regs.off_l};
  assign full_on  = regs.on_h[FULL_BIT];
  assign full_off = regs.off_h[FULL_BIT];

  // Upper bits of ON_H/OFF_H are reserved and carry no meaning here
  assign unused_reserved = ^{regs.on_h[7:5], regs.off_h[7:5]};

  // Raw channel level: full-off beats full-on, equal ON/OFF is off, and an
  // ON value above OFF describes a window that wraps through zero
  always_comb begin
    raw = 1'b0;
    if (!run_i || full_off) begin
      raw = 1'b0;
    end else if (full_on) begin
      raw = 1'b1;
    end else if (on_cnt == off_cnt) begin
      raw = 1'b0;
    end else if (on_cnt < off_cnt) begin
      raw = (counter_i >= on_cnt) && (counter_i < off_cnt);
    end else begin
      raw = (counter_i >= on_cnt) || (counter_i < off_cnt);
    end
  end

  // Pad stage: inversion first, then OE_n gating and push-pull/open-drain choice
  always_comb begin
    level = raw ^ invrt_i;
    pwm_d = 1'b0;
    oe_d  = 1'b0;
    if (!oe_ni) begin
      if (outdrv_i) begin
        pwm_d = level;
        oe_d  = 1'b1;
      end else begin
        oe_d = ~level;
      end
    end
  end

  // Registered pad outputs so the pins never carry comparator glitches
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_o    <= 1'b0;
      pwm_oe_o <= 1'b0;
    end else begin
      pwm_o    <= pwm_d;
      pwm_oe_o <= oe_d;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// PCA9685-compatible 16-channel PWM engine: oscillator divider, prescaler,
// shared 12-bit counter, SLEEP/RUN control and per-period register shadowing.
module pwm_generator
  import pwm_generator_pkg::*;
#(
  parameter int OSC_DIV      = 1,
  parameter int MIN_PRESCALE = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [0:511]         led_regs_i,
  input  logic [7:0]           prescale_i,
  input  logic                 sleep_i,
  input  logic                 invrt_i,
  input  logic                 outdrv_i,
  input  logic                 oe_ni,
  output logic [15:0]          pwm_o,
  output logic [15:0]          pwm_oe_o,
  output logic [PWM_CNT_W-1:0] counter_o,
  output logic                 period_o
);

  localparam logic [7:0] OSC_LAST     = 8'(OSC_DIV - 1);
  localparam logic [7:0] PRESCALE_MIN = 8'(MIN_PRESCALE);

  logic [0:0]           state_q;
  logic [7:0]           osc_div_q;
  logic [7:0]           presc_div_q;
  logic [7:0]           prescale_q;
  logic [PWM_CNT_W-1:0] counter_q;
  logic [0:511]         shadow_q;
  logic                 period_q;

  logic                 run;
  logic                 wake;
  logic                 tick;
  logic                 advance;
  logic                 wrap;
  logic [7:0]           prescale_eff;

  // Timing strobes derived from the divider chain
  always_comb begin
    run          = (state_q == ST_RUN);
    wake         = !run && !sleep_i;
    tick         = run && (osc_div_q == OSC_LAST);
    advance      = tick && (presc_div_q == prescale_q);
    wrap         = advance && (counter_q == PWM_CNT_MAX);
    prescale_eff = clamp_prescale(prescale_i, PRESCALE_MIN);
  end

  // SLEEP/RUN control, divider chain, counter and the period-boundary
  // shadow/prescale reload; a wrap coinciding with sleep still reloads the shadow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_SLEEP;
      osc_div_q   <= '0;
      presc_div_q <= '0;
      prescale_q  <= '0;
      counter_q   <= '0;
      shadow_q    <= '0;
      period_q    <= 1'b0;
    end else begin
      period_q <= 1'b0;
      if (wake) begin
        state_q     <= ST_RUN;
        osc_div_q   <= '0;
        presc_div_q <= '0;
        counter_q   <= '0;
        shadow_q    <= led_regs_i;
        prescale_q  <= prescale_eff;
      end else if (run && sleep_i) begin
        state_q     <= ST_SLEEP;
        osc_div_q   <= '0;
        presc_div_q <= '0;
        counter_q   <= '0;
        if (wrap) begin
          shadow_q <= led_regs_i;
          period_q <= 1'b1;
        end
      end else if (run) begin
        osc_div_q <= tick ? 8'd0 : osc_div_q + 8'd1;
        if (tick) begin
          presc_div_q <= advance ? 8'd0 : presc_div_q + 8'd1;
        end
        if (advance) begin
          counter_q <= counter_q + 12'd1;
        end
        if (wrap) begin
          shadow_q   <= led_regs_i;
          prescale_q <= prescale_eff;
          period_q   <= 1'b1;
        end
      end
    end
  end

  assign counter_o = counter_q;
  assign period_o  = period_q;

  for (genvar n = 0; n < 16; n++) begin : g_chan
    pwm_channel u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .shadow_i (shadow_q[32*n +: 32]),
      .counter_i(counter_q),
      .run_i    (run),
      .invrt_i  (invrt_i),
      .outdrv_i (outdrv_i),
      .oe_ni    (oe_ni),
      .pwm_o    (pwm_o[n]),
      .pwm_oe_o (pwm_oe_o[n])
    );
  end

endmodule
